// File: rtl/dmem_arb_pkg.sv
// Shared types, region map and access-legality check for the data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10
   } size_e;

   // Address bits [11:8] select the region.
   localparam logic [3:0] RAM_HI = 4'h7;
   localparam logic [3:0] OUTP   = 4'h8;
   localparam logic [3:0] INP    = 4'h9;

   // Flags misaligned, illegal-size, out-of-map and switch-store accesses.
   function automatic logic access_err(input logic [11:0] addr_lo,
                                       input logic        hi_nz,
                                       input logic [1:0]  size,
                                       input logic        we);
      logic       e;
      logic [3:0] region;
      region = addr_lo[11:8];
      e = hi_nz;
      if (size == 2'b11) e = 1'b1;
      if ((size == SZ_H) && addr_lo[0]) e = 1'b1;
      if ((size == SZ_W) && (addr_lo[1:0] != 2'b00)) e = 1'b1;
      if (!((region <= RAM_HI) || (region == OUTP) || (region == INP))) e = 1'b1;
      if (we && (region == INP)) e = 1'b1;
      return e;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side bus of the data-memory arbiter.
interface dmem_arbiter_if #(parameter int unsigned W = 32);
   logic [1:0]   req_i;
   logic [1:0]   we_i;
   logic [W-1:0] addr0_i;
   logic [W-1:0] addr1_i;
   logic [W-1:0] wdata0_i;
   logic [W-1:0] wdata1_i;
   logic [1:0]   size0_i;
   logic [1:0]   size1_i;
   logic [1:0]   uns_i;
   logic [1:0]   gnt_o;
   logic [1:0]   rvalid_o;
   logic [W-1:0] rdata_o;
   logic         rerr_o;
   logic         mem_st_en_o;
   logic [W-1:0] mem_addr_o;
   logic [W-1:0] mem_st_data_o;
   logic [1:0]   mem_sel_mod_o;
   logic         mem_unsigned_o;
   logic [W-1:0] mem_ld_data_i;

   modport slave (
      input  req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
             size0_i, size1_i, uns_i, mem_ld_data_i,
      output gnt_o, rvalid_o, rdata_o, rerr_o, mem_st_en_o, mem_addr_o,
             mem_st_data_o, mem_sel_mod_o, mem_unsigned_o
   );

   modport master (
      output req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
             size0_i, size1_i, uns_i, mem_ld_data_i,
      input  gnt_o, rvalid_o, rdata_o, rerr_o, mem_st_en_o, mem_addr_o,
             mem_st_data_o, mem_sel_mod_o, mem_unsigned_o
   );
endinterface

// File: rtl/dmem_arb_prio.sv
// Two-port grant logic: port 0 wins ties until port 1 has waited MAX_STARVE grants.
module dmem_arb_prio #(
   parameter int unsigned MAX_STARVE = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);
   localparam int unsigned CW = 4;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          starved;

   // Grant selection and starvation-count update.
   always_comb begin
      gnt_o   = 2'b00;
      cnt_d   = cnt_q;
      starved = (cnt_q == CW'(MAX_STARVE));
      if (!rst_i) begin
         if (req_i[0] && req_i[1]) gnt_o = starved ? 2'b10 : 2'b01;
         else if (req_i[0])        gnt_o = 2'b01;
         else if (req_i[1])        gnt_o = 2'b10;
      end
      if (gnt_o[1] || !req_i[1])       cnt_d = '0;
      else if (gnt_o[0] && !starved)   cnt_d = cnt_q + CW'(1);
   end

   // Starvation counter register.
   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto one data-memory/MMIO port with a one-cycle response.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned W          = 32,
   parameter int unsigned MAX_STARVE = 4
) (
   input  logic           clk_i,
   input  logic           rst_i,
   dmem_arbiter_if.slave  bus
);
   logic [1:0]   gnt;
   logic         any_gnt;
   logic         sel1;
   logic         we_w;
   logic         uns_w;
   logic         err_w;
   logic [W-1:0] addr_w;
   logic [W-1:0] wdata_w;
   logic [1:0]   size_w;

   logic [W-1:0] addr_q;
   logic [W-1:0] wdata_q;
   logic [1:0]   size_q;
   logic         uns_q;

   logic [1:0]   rvalid_q;
   logic [W-1:0] rdata_q;
   logic         rerr_q;

   dmem_arb_prio #(.MAX_STARVE(MAX_STARVE)) u_prio (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .req_i (bus.req_i),
      .gnt_o (gnt)
   );

   // Winner mux and legality check of the granted access.
   always_comb begin
      any_gnt = |gnt;
      sel1    = gnt[1];
      addr_w  = sel1 ? bus.addr1_i  : bus.addr0_i;
      wdata_w = sel1 ? bus.wdata1_i : bus.wdata0_i;
      size_w  = sel1 ? bus.size1_i  : bus.size0_i;
      we_w    = sel1 ? bus.we_i[1]  : bus.we_i[0];
      uns_w   = sel1 ? bus.uns_i[1] : bus.uns_i[0];
      err_w   = access_err(addr_w[11:0], |addr_w[W-1:12], size_w, we_w);
   end

   // Memory port drive; idle cycles replay the last granted access fields.
   always_comb begin
      bus.gnt_o          = gnt;
      bus.mem_st_en_o    = any_gnt & we_w & ~err_w;
      bus.mem_addr_o     = any_gnt ? addr_w  : addr_q;
      bus.mem_st_data_o  = any_gnt ? wdata_w : wdata_q;
      bus.mem_sel_mod_o  = any_gnt ? size_w  : size_q;
      bus.mem_unsigned_o = any_gnt ? uns_w   : uns_q;
      bus.rvalid_o       = rvalid_q;
      bus.rdata_o        = rdata_q;
      bus.rerr_o         = rerr_q;
   end

   // Hold registers for the memory-side fields.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= SZ_W;
         uns_q   <= 1'b0;
      end else if (any_gnt) begin
         addr_q  <= addr_w;
         wdata_q <= wdata_w;
         size_q  <= size_w;
         uns_q   <= uns_w;
      end
   end

   // One-cycle response: load data and error captured at the grant edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rvalid_q <= 2'b00;
         rdata_q  <= '0;
         rerr_q   <= 1'b0;
      end else begin
         rvalid_q <= gnt;
         rerr_q   <= any_gnt & err_w;
         rdata_q  <= (any_gnt && !we_w && !err_w) ? bus.mem_ld_data_i : '0;
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed memory behind the port.
module tb_dmem_arbiter;
   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;

   logic [7:0]  mem [0:4095];
   logic [11:0] ma;
   logic [31:0] ld;

   dmem_arbiter_if #(.W(32)) bus ();

   dmem_arbiter #(.W(32), .MAX_STARVE(4)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: extends loads itself, takes lane-aligned store data.
   assign ma = bus.mem_addr_o[11:0];
   always_comb begin
      case (bus.mem_sel_mod_o)
         2'b00:   ld = bus.mem_unsigned_o ? {24'h0, mem[ma]} : {{24{mem[ma][7]}}, mem[ma]};
         2'b01:   ld = bus.mem_unsigned_o ? {16'h0, mem[ma+12'd1], mem[ma]}
                                          : {{16{mem[ma+12'd1][7]}}, mem[ma+12'd1], mem[ma]};
         default: ld = {mem[ma+12'd3], mem[ma+12'd2], mem[ma+12'd1], mem[ma]};
      endcase
      bus.mem_ld_data_i = ld;
   end

   always @(posedge clk) begin
      if (bus.mem_st_en_o) begin
         case (bus.mem_sel_mod_o)
            2'b00: mem[ma] <= bus.mem_st_data_o[8*ma[1:0] +: 8];
            2'b01: begin
               mem[ma]        <= bus.mem_st_data_o[8*ma[1:0] +: 8];
               mem[ma+12'd1]  <= bus.mem_st_data_o[8*ma[1:0]+8 +: 8];
            end
            default: begin
               mem[ma]       <= bus.mem_st_data_o[7:0];
               mem[ma+12'd1] <= bus.mem_st_data_o[15:8];
               mem[ma+12'd2] <= bus.mem_st_data_o[23:16];
               mem[ma+12'd3] <= bus.mem_st_data_o[31:24];
            end
         endcase
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int p, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] sz, input logic u);
      bus.req_i[p] = 1'b1;
      bus.we_i[p]  = we;
      bus.uns_i[p] = u;
      if (p == 0) begin
         bus.addr0_i = a; bus.wdata0_i = wd; bus.size0_i = sz;
      end else begin
         bus.addr1_i = a; bus.wdata1_i = wd; bus.size1_i = sz;
      end
   endtask

   task automatic idle();
      bus.req_i = 2'b00;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      tick(); tick();
      #1;
      n_total++;
      if ({bus.gnt_o, bus.rvalid_o, bus.rerr_o, bus.mem_st_en_o, bus.mem_unsigned_o} !== 7'b0)
         $display("FAIL reset_ctrl: got %b want 0",
                  {bus.gnt_o, bus.rvalid_o, bus.rerr_o, bus.mem_st_en_o, bus.mem_unsigned_o});
      else n_pass++;
      n_total++;
      if ({bus.rdata_o, bus.mem_addr_o, bus.mem_st_data_o} !== 96'h0)
         $display("FAIL reset_data: got %h want 0", {bus.rdata_o, bus.mem_addr_o, bus.mem_st_data_o});
      else n_pass++;
      n_total++;
      if (bus.mem_sel_mod_o !== 2'b10) $display("FAIL reset_sel: got %b want 10", bus.mem_sel_mod_o);
      else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_store_load();
      tick();
      drive(0, 1'b1, 32'h010, 32'hDEADBEEF, 2'b10, 1'b0);
      #1;
      n_total++;
      if ({bus.gnt_o, bus.mem_st_en_o} !== 3'b011)
         $display("FAIL st_gnt: got %b want 011", {bus.gnt_o, bus.mem_st_en_o});
      else n_pass++;
      tick();
      drive(0, 1'b0, 32'h010, 32'h0, 2'b10, 1'b0);
      #1;
      n_total++;
      if ({bus.gnt_o, bus.mem_st_en_o, bus.rvalid_o, bus.rerr_o} !== 6'b010010)
         $display("FAIL ld_gnt: got %b want 010010", {bus.gnt_o, bus.mem_st_en_o, bus.rvalid_o, bus.rerr_o});
      else n_pass++;
      tick();
      idle();
      #1;
      n_total++;
      if ({bus.rvalid_o, bus.rerr_o, bus.rdata_o} !== {2'b01, 1'b0, 32'hDEADBEEF})
         $display("FAIL ld_resp: got %b/%b/%h want 01/0/deadbeef", bus.rvalid_o, bus.rerr_o, bus.rdata_o);
      else n_pass++;
   endtask

   task automatic test_starve();
      logic [1:0] rq  [18] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11,
                               2'b11, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
      logic [1:0] exp [18] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01,
                               2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
      tick();
      drive(0, 1'b0, 32'h000, 32'h0, 2'b10, 1'b0);
      drive(1, 1'b0, 32'h010, 32'h0, 2'b10, 1'b0);
      for (int i = 0; i < 18; i++) begin
         bus.req_i = rq[i];
         #1;
         n_total++;
         if (bus.gnt_o !== exp[i]) $display("FAIL starve_gnt[%0d]: got %b want %b", i, bus.gnt_o, exp[i]);
         else n_pass++;
         if (i > 0) begin
            n_total++;
            if (bus.rvalid_o !== exp[i-1])
               $display("FAIL starve_rvalid[%0d]: got %b want %b", i, bus.rvalid_o, exp[i-1]);
            else n_pass++;
         end
         tick();
      end
      idle();
   endtask

   task automatic test_errors();
      logic [31:0] ea [7] = '{32'h003, 32'h900, 32'h002, 32'hA00, 32'h1000, 32'h004, 32'h904};
      logic [1:0]  es [7] = '{2'b01,   2'b10,   2'b10,   2'b00,   2'b00,    2'b11,   2'b10};
      logic        ew [7] = '{1'b0,    1'b1,    1'b0,    1'b0,    1'b0,     1'b0,    1'b0};
      logic        ee [7] = '{1'b1,    1'b1,    1'b1,    1'b1,    1'b1,     1'b1,    1'b0};
      for (int i = 0; i < 7; i++) begin
         tick();
         drive(1, ew[i], ea[i], 32'h12345678, es[i], 1'b0);
         #1;
         n_total++;
         if ({bus.gnt_o, bus.mem_st_en_o} !== {2'b10, ew[i] & ~ee[i]})
            $display("FAIL err_gnt[%0d]: got %b want %b", i, {bus.gnt_o, bus.mem_st_en_o}, {2'b10, ew[i] & ~ee[i]});
         else n_pass++;
         tick();
         idle();
         #1;
         n_total++;
         if ({bus.rvalid_o, bus.rerr_o, bus.rdata_o} !== {2'b10, ee[i], 32'h0})
            $display("FAIL err_resp[%0d]: got %b/%b/%h want 10/%b/0", i, bus.rvalid_o, bus.rerr_o, bus.rdata_o, ee[i]);
         else n_pass++;
      end
      n_total++;
      if ({mem[12'h903], mem[12'h902], mem[12'h901], mem[12'h900]} !== 32'h0)
         $display("FAIL sw_untouched: got %h want 0", {mem[12'h903], mem[12'h902], mem[12'h901], mem[12'h900]});
      else n_pass++;
   endtask

   task automatic test_bytes();
      logic [31:0] sa [2] = '{32'h802, 32'h803};
      logic [31:0] sd [2] = '{32'h005A0000, 32'hA5000000};
      logic [31:0] la [4] = '{32'h802, 32'h803, 32'h802, 32'h802};
      logic [1:0]  ls [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
      logic        lu [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [31:0] lx [4] = '{32'h0000005A, 32'hFFFFFFA5, 32'h0000A55A, 32'hFFFFA55A};
      for (int i = 0; i < 2; i++) begin
         tick();
         drive(0, 1'b1, sa[i], sd[i], 2'b00, 1'b0);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         drive(0, 1'b0, la[i], 32'h0, ls[i], lu[i]);
         tick();
         idle();
         #1;
         n_total++;
         if ({bus.rvalid_o, bus.rerr_o, bus.rdata_o} !== {2'b01, 1'b0, lx[i]})
            $display("FAIL byte_ld[%0d]: got %b/%b/%h want 01/0/%h", i, bus.rvalid_o, bus.rerr_o, bus.rdata_o, lx[i]);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      tick();
      drive(1, 1'b1, 32'h020, 32'h11111111, 2'b10, 1'b0);
      tick();
      bus.req_i[1] = 1'b0;
      drive(0, 1'b0, 32'h020, 32'h0, 2'b10, 1'b0);
      #1;
      n_total++;
      if ({bus.gnt_o, bus.rvalid_o} !== 4'b0110)
         $display("FAIL b2b_overlap: got %b want 0110", {bus.gnt_o, bus.rvalid_o});
      else n_pass++;
      tick();
      drive(0, 1'b0, 32'h010, 32'h0, 2'b10, 1'b0);
      #1;
      n_total++;
      if ({bus.gnt_o, bus.rvalid_o, bus.rdata_o} !== {4'b0101, 32'h11111111})
         $display("FAIL b2b_first: got %b/%h want 0101/11111111", {bus.gnt_o, bus.rvalid_o}, bus.rdata_o);
      else n_pass++;
      tick();
      idle();
      #1;
      n_total++;
      if ({bus.rvalid_o, bus.rdata_o} !== {2'b01, 32'hDEADBEEF})
         $display("FAIL b2b_second: got %b/%h want 01/deadbeef", bus.rvalid_o, bus.rdata_o);
      else n_pass++;
   endtask

   task automatic test_idle_hold();
      tick();
      drive(0, 1'b0, 32'h0AC, 32'h0, 2'b01, 1'b1);
      tick();
      idle();
      for (int i = 0; i < 3; i++) begin
         if (i > 0) tick();
         #1;
         n_total++;
         if ({bus.gnt_o, bus.mem_st_en_o, bus.rvalid_o} !== {3'b000, (i == 0) ? 2'b01 : 2'b00})
            $display("FAIL idle_ctrl[%0d]: got %b", i, {bus.gnt_o, bus.mem_st_en_o, bus.rvalid_o});
         else n_pass++;
         n_total++;
         if ({bus.mem_addr_o, bus.mem_sel_mod_o, bus.mem_unsigned_o} !== {32'h0AC, 2'b01, 1'b1})
            $display("FAIL idle_hold[%0d]: got %h/%b/%b want 0ac/01/1", i,
                     bus.mem_addr_o, bus.mem_sel_mod_o, bus.mem_unsigned_o);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0] exp [5] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
      tick();
      drive(0, 1'b0, 32'h010, 32'h0, 2'b10, 1'b0);
      tick();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      n_total++;
      if ({bus.rvalid_o, bus.rdata_o} !== 34'h0)
         $display("FAIL rst_drop: got %b/%h want 00/0", bus.rvalid_o, bus.rdata_o);
      else n_pass++;
      // Build up the counter, then reset while both still request.
      drive(0, 1'b0, 32'h000, 32'h0, 2'b10, 1'b0);
      drive(1, 1'b0, 32'h010, 32'h0, 2'b10, 1'b0);
      tick(); tick(); tick();
      rst = 1'b1;
      #1;
      n_total++;
      if (bus.gnt_o !== 2'b00) $display("FAIL rst_gnt: got %b want 00", bus.gnt_o);
      else n_pass++;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_total++;
         if (bus.gnt_o !== exp[i]) $display("FAIL rst_cnt[%0d]: got %b want %b", i, bus.gnt_o, exp[i]);
         else n_pass++;
         tick();
      end
      idle();
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      rst           = 1'b1;
      bus.req_i     = 2'b00;
      bus.we_i      = 2'b00;
      bus.uns_i     = 2'b00;
      bus.addr0_i   = '0;
      bus.addr1_i   = '0;
      bus.wdata0_i  = '0;
      bus.wdata1_i  = '0;
      bus.size0_i   = 2'b10;
      bus.size1_i   = 2'b10;
      test_reset();
      test_store_load();
      test_starve();
      test_errors();
      test_bytes();
      test_back_to_back();
      test_idle_hold();
      test_reset_mid();
      tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory/MMIO port (RAM 0x000–0x7FF, output peripherals 0x800–0x8FF, switch input 0x900–0x9FF) between two requesters.
- Port 0 is the core load/store unit. Port 1 is the debug/DMA loader.
- Each cycle the arbiter grants one request and drives the memory port combinationally. It registers load data and the error flag, and returns a one-cycle response.
- It checks alignment and the address region. A bounded-starvation priority scheme keeps port 1 from being locked out.

Parameters:
- W, 32, data/address width.
- MAX_STARVE, 4, consecutive port-0 grants allowed while port 1 waits; range 1..15.

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  synchronous reset, active-high
- req_i  in  2  per-port request, held until granted
- we_i  in  2  per-port store(1)/load(0)
- addr0_i / addr1_i  in  W  byte address
- wdata0_i / wdata1_i  in  W  store data, byte-lane-aligned to addr[1:0]
- size0_i / size1_i  in  2  00 B, 01 H, 10 W, 11 illegal
- uns_i  in  2  per-port unsigned-load flag
- gnt_o  out  2  one-hot grant; combinational, same cycle as req
- rvalid_o  out  2  response valid, exactly 1 cycle after grant
- rdata_o  out  W  shared load data, qualified by rvalid_o
- rerr_o  out  1  response error, qualified by rvalid_o
- mem_st_en_o  out  1  to memory: write enable
- mem_addr_o  out  W  to memory: address
- mem_st_data_o  out  W  to memory: store data
- mem_sel_mod_o  out  2  to memory: access size
- mem_unsigned_o  out  1  to memory: unsigned-load flag
- mem_ld_data_i  in  W  from memory: combinational load data

Behaviour:
- Reset values:
  - gnt_o=0, rvalid_o=0, rdata_o=0, rerr_o=0
  - mem_st_en_o=0, mem_addr_o=0, mem_st_data_o=0, mem_sel_mod_o=2'b10, mem_unsigned_o=0
  - starve_cnt=0
- Reset mid-operation: a pending response is dropped (rvalid_o=0 next cycle). Requesters must re-issue.
- Arbitration (combinational, each cycle):
  - Only req_i[0]: grant 0.
  - Only req_i[1]: grant 1.
  - Both requesting: grant 1 if starve_cnt==MAX_STARVE, else grant 0.
  - No request: gnt_o=0, mem_st_en_o=0, mem_addr_o/mem_st_data_o/mem_sel_mod_o/mem_unsigned_o hold their last driven values.
- Starvation counter:
  - Increments when port 0 is granted while req_i[1]=1.
  - Clears when port 1 is granted, or when req_i[1]=0.
  - Saturates at MAX_STARVE.
- Memory drive: in the grant cycle, addr/st_data/sel_mod/unsigned are muxed from the winner. mem_st_en_o = winner we & ~err.
- Error (err) is set for a granted access if any of these hold; a store with err set is suppressed:
  - size==11
  - size H with addr[0]=1
  - size W with addr[1:0]!=0
  - addr[11:8] > 4'h9
  - addr[W-1:12] != 0
  - store to 0x900–0x9FF (read-only switches)
- Response pipeline:
  - rvalid_o[winner] is set 1 cycle after grant, for both load and store, and lasts 1 cycle.
  - rdata_o = mem_ld_data_i sampled at the grant edge for a load without error; otherwise 0.
  - rerr_o = err sampled at the grant edge.
- Back-to-back: a new grant may issue in the same cycle as a response. Throughput is 1 access/cycle.
- Same-port consecutive requests are allowed.
- Load latency 1, store commit at the grant edge.

Decomposition:
- Package dmem_arb_pkg holds:
  - size_e (SZ_B, SZ_H, SZ_W)
  - region constants: RAM_HI=4'h7, OUTP=4'h8, INP=4'h9
  - function access_err(addr, size, we)
- Sub-module dmem_arb_prio: starvation counter plus grant logic (req_i, MAX_STARVE → gnt); unit-testable alone.

Test Plan:
- Port 0 only, store W 0xDEADBEEF @0x010 then load W @0x010 → gnt_o=01 both cycles; second rvalid_o[0] has rdata_o=0xDEADBEEF, rerr_o=0.
- Both ports request continuously, MAX_STARVE=4 → grant sequence 0,0,0,0,1,0,0,0,0,1…
- Port 1 load H @0x003 → rvalid_o[1]=1, rerr_o=1, rdata_o=0. Port 1 store W @0x900 → rerr_o=1, mem_st_en_o=0, memory unchanged.
- Store B 0x5A @0x802 (LEDs) then load B unsigned @0x802 → rdata_o=0x0000005A. Signed load of 0xA5 byte → 0xFFFFFFA5.
- rst_i asserted in the cycle after a grant → rvalid_o=0, rdata_o=0, starve_cnt=0 on the following cycle.
- No requests for 3 cycles → gnt_o=0, mem_st_en_o=0, rvalid_o=0 throughout.
